// File: rtl/ddc_ctrl.sv
// ddc_ctrl: frame-aligned DDC reconfiguration (flush + settle) and ping-pong I/Q frame capture with valid/ready replay.
// out_valid 1 cycle after frame end; out_ready low holds words, a frame arriving with both banks full is dropped; DDC_CTRL_DROP_CNT_EN builds drop_cnt.
module ddc_ctrl #(
  parameter int nadc          = 8,
  parameter int rw            = 20,
  parameter int pcw           = 13,
  parameter int flush_cyc     = 16,
  parameter int settle_frames = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [pcw-1:0]       cfg_period,
  input  logic [3:0]           cfg_shift,
  input  logic                 cfg_we,
  output logic                 cfg_busy,
  output logic [pcw-1:0]       ddc_period,
  output logic [3:0]           ddc_shift,
  output logic                 ddc_reset,
  input  logic signed [rw-1:0] iq_in,
  input  logic                 iq_stb,
  output logic [rw-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [15:0]          drop_cnt,
  output logic                 err_frame
);
  localparam int NW  = 2 * nadc;
  localparam int WCW = $clog2(NW + 2);
  localparam int RIW = $clog2(NW);
  localparam int FCW = $clog2(flush_cyc + 1);
  localparam int SCW = $clog2(settle_frames + 2);

  typedef enum logic [1:0] {S_RUN, S_WAIT_EOF, S_FLUSH, S_SETTLE} state_t;

  state_t         state, state_nx;
  logic           cfg_acc;
  logic [FCW-1:0] fcnt;
  logic [SCW-1:0] scnt;
  logic [pcw-1:0] pend_period;
  logic [3:0]     pend_shift;

  logic [WCW-1:0] wc;
  logic           stb_q, cap_ok, room;
  logic           start, room_now, fall, frame_done, frame_bad, keep;
  logic           wsel, rd_full, wr_full;
  logic [RIW-1:0] rd_idx;
  logic           last_hs, rd_free;
  logic [rw-1:0]  mem [2][NW];

  assign start      = iq_stb & ~stb_q;
  assign room_now   = start ? ~wr_full : room;
  assign fall       = stb_q & ~iq_stb;
  assign frame_done = fall && (wc == WCW'(NW));
  assign frame_bad  = fall && (wc != WCW'(NW));
  assign keep       = frame_done & cap_ok;

  assign cfg_busy  = (state != S_RUN);
  assign ddc_reset = (state == S_FLUSH);

  always_comb begin
    state_nx = state;
    cfg_acc  = 1'b0;
    case (state)
      S_RUN: begin
        if (cfg_we) begin
          cfg_acc  = 1'b1;
          state_nx = S_WAIT_EOF;
        end
      end
      S_WAIT_EOF: if (!iq_stb) state_nx = S_FLUSH;
      S_FLUSH: begin
        if (fcnt == FCW'(flush_cyc - 1))
          state_nx = (settle_frames == 0) ? S_RUN : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_frames == 0 || (frame_done && scnt == SCW'(settle_frames - 1)))
          state_nx = S_RUN;
      end
      default: state_nx = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FLUSH;
      fcnt        <= '0;
      scnt        <= '0;
      pend_period <= pcw'(33);
      pend_shift  <= 4'd7;
      ddc_period  <= pcw'(33);
      ddc_shift   <= 4'd7;
    end else begin
      state <= state_nx;
      if (cfg_acc) begin
        pend_period <= cfg_period;
        pend_shift  <= cfg_shift;
      end
      // new settings reach the DDC on the same edge that raises ddc_reset
      if (state != S_FLUSH && state_nx == S_FLUSH) begin
        ddc_period <= pend_period;
        ddc_shift  <= pend_shift;
      end
      fcnt <= (state == S_FLUSH) ? fcnt + 1'b1 : '0;
      if (state != S_SETTLE)
        scnt <= '0;
      else if (frame_done)
        scnt <= scnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wc        <= '0;
      stb_q     <= 1'b0;
      cap_ok    <= 1'b0;
      room      <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      stb_q <= iq_stb;
      if (!iq_stb)
        wc <= '0;
      else if (wc != WCW'(NW + 1))
        wc <= wc + 1'b1;
      if (start) begin
        cap_ok <= (state == S_RUN) || (state == S_WAIT_EOF);
        room   <= ~wr_full;
      end
      if (frame_bad)
        err_frame <= 1'b1;
    end
  end

  // a frame that starts with the write bank occupied is never written, so the held frame survives
  always_ff @(posedge clk) begin
    if (iq_stb && room_now && (wc < WCW'(NW)))
      mem[wsel][wc[RIW-1:0]] <= iq_in;
  end

  assign out_valid = rd_full;
  assign out_last  = rd_full && (rd_idx == RIW'(NW - 1));
  assign out_data  = rd_full ? mem[~wsel][rd_idx] : '0;
  assign last_hs   = out_valid & out_ready & out_last;
  assign rd_free   = ~rd_full | last_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      wsel    <= 1'b0;
      rd_full <= 1'b0;
      wr_full <= 1'b0;
      rd_idx  <= '0;
    end else begin
      if (out_valid && out_ready)
        rd_idx <= out_last ? '0 : rd_idx + 1'b1;
      if (keep && room && rd_free) begin
        wsel    <= ~wsel;
        rd_full <= 1'b1;
      end else if (last_hs && wr_full) begin
        wsel    <= ~wsel;
        wr_full <= 1'b0;
      end else if (last_hs) begin
        rd_full <= 1'b0;
      end else if (keep && room) begin
        wr_full <= 1'b1;
      end
    end
  end

`ifdef DDC_CTRL_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (keep && !room && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ddc_ctrl.sv
// Randomized scoreboard bench for ddc_ctrl against a frame-level reference model.
module tb_ddc_ctrl;
  localparam int NADC = 8, NW = 2 * NADC, RW = 20, PCW = 13, FLUSH = 16, SETTLE = 2;

`ifdef DDC_CTRL_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic                 clk = 1'b0, reset = 1'b1;
  logic [PCW-1:0]       cfg_period = '0;
  logic [3:0]           cfg_shift = '0;
  logic                 cfg_we = 1'b0;
  logic                 cfg_busy;
  logic [PCW-1:0]       ddc_period;
  logic [3:0]           ddc_shift;
  logic                 ddc_reset;
  logic signed [RW-1:0] iq_in = '0;
  logic                 iq_stb = 1'b0;
  logic [RW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic [15:0]          drop_cnt;
  logic                 err_frame;

  always #5 clk = ~clk;

  ddc_ctrl #(.nadc(NADC), .rw(RW), .pcw(PCW), .flush_cyc(FLUSH), .settle_frames(SETTLE)) dut (
    .clk(clk), .reset(reset), .cfg_period(cfg_period), .cfg_shift(cfg_shift), .cfg_we(cfg_we),
    .cfg_busy(cfg_busy), .ddc_period(ddc_period), .ddc_shift(ddc_shift), .ddc_reset(ddc_reset),
    .iq_in(iq_in), .iq_stb(iq_stb), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .drop_cnt(drop_cnt), .err_frame(err_frame)
  );

  typedef struct { logic [RW-1:0] d; bit last; } word_t;
  word_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int rdy_mode = 2;  // 0 random, 1 held low, 2 always high, 3 driven by the stimulus thread

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame/transaction level) ----------------
  typedef enum {M_RUN, M_WAIT, M_FLUSH, M_SETTLE} mode_t;
  mode_t          m_mode;
  int             flush_left, settle_left, occ, rd_words, m_drop;
  bit             m_err, prev_stb, f_show, f_room;
  logic [PCW-1:0] m_period, p_period;
  logic [3:0]     m_shift, p_shift;
  logic [RW-1:0]  fw[$];

  always @(negedge clk) begin
    if (reset) begin
      m_mode = M_FLUSH; flush_left = FLUSH; settle_left = SETTLE;
      occ = 0; rd_words = 0; m_drop = 0; m_err = 0; prev_stb = 0;
      m_period = 33; m_shift = 7; p_period = 33; p_shift = 7;
      fw.delete(); exp_q.delete();
    end else begin
      bit hs_last, acc;
      chk("cfg_busy", 32'(cfg_busy), 32'(m_mode != M_RUN));
      chk("ddc_reset", 32'(ddc_reset), 32'(m_mode == M_FLUSH));
      chk("ddc_period", 32'(ddc_period), 32'(m_period));
      chk("ddc_shift", 32'(ddc_shift), 32'(m_shift));
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("err_frame", 32'(err_frame), 32'(m_err));
      chk("drop_cnt", 32'(drop_cnt), DROP_EN ? 32'(m_drop) : 32'd0);

      hs_last = 0;
      if (out_valid && out_ready) begin
        rd_words++;
        if (rd_words == NW) begin rd_words = 0; hs_last = 1; end
      end

      if (iq_stb) begin
        if (!prev_stb) begin
          f_show = (m_mode == M_RUN) || (m_mode == M_WAIT);
          f_room = (occ < 2);
          fw.delete();
        end
        fw.push_back(iq_in);
      end

      acc = 0;
      if (prev_stb && !iq_stb) begin
        if (fw.size() == NW) begin
          if (m_mode == M_SETTLE && settle_left > 0) settle_left--;
          if (f_show) begin
            if (f_room) begin
              for (int i = 0; i < NW; i++) exp_q.push_back('{d: fw[i], last: (i == NW - 1)});
              acc = 1;
            end else if (m_drop < 16'hFFFF) begin
              m_drop++;
            end
          end
        end else begin
          m_err = 1;
        end
      end
      occ = occ - int'(hs_last) + int'(acc);
      prev_stb = iq_stb;

      case (m_mode)
        M_RUN: if (cfg_we) begin p_period = cfg_period; p_shift = cfg_shift; m_mode = M_WAIT; end
        M_WAIT: if (!iq_stb) begin
          m_mode = M_FLUSH; flush_left = FLUSH; m_period = p_period; m_shift = p_shift;
        end
        M_FLUSH: begin
          flush_left--;
          if (flush_left == 0) begin
            settle_left = SETTLE;
            m_mode = (SETTLE == 0) ? M_RUN : M_SETTLE;
          end
        end
        default: if (settle_left == 0) m_mode = M_RUN;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_word: got %0h expected no word at %0t", out_data, $time);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'($urandom_range(0, 1));
      1: out_ready = 1'b0;
      2: out_ready = 1'b1;
      default: ;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input int n, input int cfg_at, input logic [PCW-1:0] p, input logic [3:0] s);
    for (int i = 0; i < n; i++) begin
      iq_stb = 1'b1; iq_in = RW'($urandom);
      cfg_we = (i == cfg_at); cfg_period = p; cfg_shift = s;
      tick();
    end
    iq_stb = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_err_frame", 32'(err_frame), 0);
    chk("rst_cfg_busy", 32'(cfg_busy), 1);
    chk("rst_ddc_reset", 32'(ddc_reset), 1);
    chk("rst_ddc_period", 32'(ddc_period), 33);
    chk("rst_ddc_shift", 32'(ddc_shift), 7);
    tick(); reset = 1'b0;

    // bring-up: flush, two settle frames, then one delivered frame
    idle(20);
    for (int f = 0; f < 3; f++) begin send_frame(NW, -1, 0, 0); idle(4); end
    idle(20);

    // random traffic with random backpressure
    rdy_mode = 0;
    for (int f = 0; f < 4; f++) begin send_frame(NW, -1, 0, 0); idle($urandom_range(1, 5)); end
    rdy_mode = 2; idle(40);

    // reconfiguration mid-frame, then an ignored write while busy
    send_frame(NW, 5, 13'd66, 4'd9); idle(3);
    cfg_we = 1'b1; cfg_period = 13'd100; cfg_shift = 4'd3; tick(); cfg_we = 1'b0;
    idle(20);
    for (int f = 0; f < 3; f++) begin send_frame(NW, -1, 0, 0); idle(4); end
    idle(20);

    // overrun: three frames while the consumer stalls
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin send_frame(NW, -1, 0, 0); idle(4); end
    idle(5); rdy_mode = 2; idle(40);

    // malformed short frame followed by a good one
    send_frame(10, -1, 0, 0); idle(4);
    send_frame(NW, -1, 0, 0); idle(25);

    // frame completion coincident with the final read handshake
    rdy_mode = 3; out_ready = 1'b1;
    send_frame(NW, -1, 0, 0); tick();
    for (int i = 0; i < NW; i++) begin
      iq_stb = 1'b1; iq_in = RW'($urandom); out_ready = (i != 0); tick();
    end
    iq_stb = 1'b0; out_ready = 1'b1; idle(25);

    // reset while a frame is held for readout
    rdy_mode = 1;
    send_frame(NW, -1, 0, 0); idle(3);
    reset = 1'b1; idle(2); reset = 1'b0; rdy_mode = 2;
    idle(20);
    for (int f = 0; f < 3; f++) begin send_frame(NW, -1, 0, 0); idle(4); end

    begin
      int w = 0;
      while ((exp_q.size() != 0 || occ != 0) && w < 500) begin tick(); w++; end
      chk("drain_pending_words", 32'(exp_q.size()), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
